// File: rtl/debounce_multi.sv
// debounce_multi: multi-channel switch debouncer.
// Each channel passes through a two-flop synchronizer. A shared prescaler then
// produces a sample tick. A per-channel counter accepts a new level only after
// STABLE_CNT consecutive ticks that disagree with the current output.
// Optional feature macro DEBOUNCE_EDGE_EN: when defined, registered one-cycle
// rise/fall pulses are generated. When undefined, rise/fall are tied to 0.
module debounce_multi #(
  parameter int WIDTH      = 4,
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [PW-1:0]    pre_cnt;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] accept;

  // Two-flop synchronizer, clocked every cycle regardless of tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  // Free-running prescaler 0..TICK_DIV-1. With TICK_DIV=1 it stays at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Tick is decoded from the prescaler. It is gated by reset so that it reads 0
  // while reset is held. This gating matters when TICK_DIV=1.
  assign tick = reset & (pre_cnt == PRE_LAST);

  // Per-channel disagreement and "last mismatching tick" decode.
  always_comb begin
    differ = sync2 ^ out;
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = tick & differ[i] & (cnt[i] == CNT_LAST);
    end
  end

  // Stability counters and debounced level. These update only on tick. An
  // agreeing sample clears a partial count, so short glitches are discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      out <= '0;
    end else if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!differ[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
        if (accept[i]) begin
          out[i] <= sync2[i];
        end
      end
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  // Edge pulses are registered on the same edge that updates out. Each pulse is
  // therefore high for exactly the cycle after out changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= accept & sync2;
      fall <= accept & ~sync2;
    end
  end
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: scoreboard bench for debounce_multi.
// Two instances are used: A (TICK_DIV=1, STABLE_CNT=4) and B (TICK_DIV=5, STABLE_CNT=2).
// The reference model keeps a shift history of tick samples per channel. out flips
// when the last STABLE_CNT samples all equal the opposite level.
module tb_debounce_multi;

  localparam int W  = 4;
  localparam int NI = 2;
  localparam int EW = 1 + 3 * W;   // {tick, fall, rise, out}

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  int div_p [NI] = '{1, 5};
  int stb_p [NI] = '{4, 2};

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_a  = '0;
  logic [W-1:0] in_b  = '0;
  logic [W-1:0] out_a, rise_a, fall_a;
  logic [W-1:0] out_b, rise_b, fall_b;
  logic         tick_a, tick_b;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  debounce_multi #(.WIDTH(W), .TICK_DIV(1), .STABLE_CNT(4)) dut_a (
    .clk(clk), .reset(reset), .in(in_a), .out(out_a),
    .rise(rise_a), .fall(fall_a), .tick(tick_a)
  );

  debounce_multi #(.WIDTH(W), .TICK_DIV(5), .STABLE_CNT(2)) dut_b (
    .clk(clk), .reset(reset), .in(in_b), .out(out_b),
    .rise(rise_b), .fall(fall_b), .tick(tick_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- comparison helpers ----------------
  task automatic cmp_word(input string name, input logic [EW-1:0] act, input logic [EW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got {tick,fall,rise,out}=%h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // ---------------- reference model (pushes expectations) ----------------
  int            m_k    [NI];
  logic [W-1:0]  m_out  [NI];
  logic [W-1:0]  m_d1   [NI];
  logic [W-1:0]  m_d2   [NI];
  logic [31:0]   m_hist [NI][W];

  always @(posedge clk) begin
    logic [W-1:0] cur_in;
    logic [W-1:0] rs;
    logic [W-1:0] fl;
    logic         tick_before;
    logic         tick_after;
    logic [31:0]  mask;
    for (int n = 0; n < NI; n++) begin
      cur_in = (n == 0) ? in_a : in_b;
      rs = '0;
      fl = '0;
      tick_after = 1'b0;
      if (!reset) begin
        m_k[n]   = 0;
        m_out[n] = '0;
        m_d1[n]  = '0;
        m_d2[n]  = '0;
        for (int c = 0; c < W; c++) m_hist[n][c] = '0;
      end else begin
        tick_before = ((m_k[n] % div_p[n]) == div_p[n] - 1);
        mask = (32'd1 << stb_p[n]) - 32'd1;
        if (tick_before) begin
          for (int c = 0; c < W; c++) begin
            m_hist[n][c] = {m_hist[n][c][30:0], m_d2[n][c]};
            if (!m_out[n][c] && ((m_hist[n][c] & mask) == mask)) begin
              m_out[n][c] = 1'b1;
              rs[c] = EDGE_EN;
            end else if (m_out[n][c] && ((m_hist[n][c] & mask) == 32'd0)) begin
              m_out[n][c] = 1'b0;
              fl[c] = EDGE_EN;
            end
          end
        end
        m_d2[n] = m_d1[n];
        m_d1[n] = cur_in;
        m_k[n]  = m_k[n] + 1;
        tick_after = ((m_k[n] % div_p[n]) == div_p[n] - 1);
      end
      if (n == 0) exp_q0.push_back({tick_after, fl, rs, m_out[n]});
      else        exp_q1.push_back({tick_after, fl, rs, m_out[n]});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (!done) begin
      if (exp_q0.size() == 0) cmp_int("queue_a_empty", 0, 1);
      else cmp_word("dut_a", {tick_a, fall_a, rise_a, out_a}, exp_q0.pop_front());
      if (exp_q1.size() == 0) cmp_int("queue_b_empty", 0, 1);
      else cmp_word("dut_b", {tick_b, fall_b, rise_b, out_b}, exp_q1.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Counts rising edges (first edge after the stimulus negedge = 1) until out_a[ch] == lvl.
  task automatic count_edges(input string name, input int ch, input logic lvl, input int exp_edges);
    int  e;
    bit  seen;
    seen = 1'b0;
    for (e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (out_a[ch] == lvl) begin
        seen = 1'b1;
        break;
      end
    end
    cmp_int(name, seen ? e : -1, exp_edges);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    idle(3);
    reset = 1'b1;

    // Clean step on channel 0: accepted at the 6th edge.
    idle(4);
    in_a[0] = 1'b1;
    count_edges("step_ch0_edges", 0, 1'b1, 6);
    idle(6);

    // 3-cycle glitch on channel 1: must be discarded.
    in_a[1] = 1'b1;
    idle(3);
    in_a[1] = 1'b0;
    idle(12);

    // Channels 0 and 3 toggle together: both complete on the same edge.
    in_a[0] = 1'b0;
    in_a[3] = 1'b1;
    count_edges("simul_ch0_fall_edges", 0, 1'b0, 6);
    idle(6);

    // Step on instance B channel 2: accepted on a tick after 2 mismatching ticks.
    in_b[2] = 1'b1;
    idle(30);
    in_b[2] = 1'b0;
    idle(30);

    // Reset mid-count with the input held high: the partial count is discarded.
    in_a[2] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    count_edges("restart_after_reset_edges", 2, 1'b1, 6);
    idle(4);

    // Randomized traffic. Flip rates are chosen so that some steps survive debounce.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(0, 7) == 0)  in_a[c] = ~in_a[c];
        if ($urandom_range(0, 24) == 0) in_b[c] = ~in_b[c];
      end
      if (cyc == 1500) reset = 1'b0;
      if (cyc == 1502) reset = 1'b1;
    end

    idle(3);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
